// File: rtl/rom_map_pkg.sv
// Shared ROM loader memory map: region indices, base/limit constants and read-back FSM types.
// Consumed by both the download selector and the upload reader so the two directions agree.
package rom_map_pkg;

   typedef enum logic [2:0] {
      REG_PROGRAM   = 3'd0,
      REG_AUDIO     = 3'd1,
      REG_GRAPHICS  = 3'd2,
      REG_DECODER   = 3'd3,
      REG_VRAM_CTRL = 3'd4,
      REG_SPRITE    = 3'd5,
      REG_TONE      = 3'd6,
      REG_UNMAPPED  = 3'd7
   } region_e;

   // Regions are contiguous and ascending; each limit is the next region's base.
   localparam logic [24:0] PROGRAM_BASE   = 25'h00000;
   localparam logic [24:0] AUDIO_BASE     = 25'h10000;
   localparam logic [24:0] GRAPHICS_BASE  = 25'h14000;
   localparam logic [24:0] DECODER_BASE   = 25'h14800;
   localparam logic [24:0] VRAM_CTRL_BASE = 25'h14900;
   localparam logic [24:0] SPRITE_BASE    = 25'h14920;
   localparam logic [24:0] TONE_BASE      = 25'h14940;
   localparam logic [24:0] MAP_LIMIT      = 25'h14960;

   localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_CAPTURE = 2'd2
   } rd_state_e;

endpackage

// File: rtl/rom_map_decode.sv
// Combinational loader-map decode: 25-bit byte address to region index, region offset,
// mapped flag and nibble-wide flag (the decoder PROM only stores 4 bits per byte).
module rom_map_decode
   import rom_map_pkg::*;
(
   input  logic [24:0] addr_i,
   output region_e     region_o,
   output logic [15:0] offset_o,
   output logic        mapped_o,
   output logic        nibble_o
);

   logic [24:0] base;

   always_comb begin
      region_o = REG_UNMAPPED;
      base     = '0;
      if (addr_i < AUDIO_BASE) begin
         region_o = REG_PROGRAM;
         base     = PROGRAM_BASE;
      end else if (addr_i < GRAPHICS_BASE) begin
         region_o = REG_AUDIO;
         base     = AUDIO_BASE;
      end else if (addr_i < DECODER_BASE) begin
         region_o = REG_GRAPHICS;
         base     = GRAPHICS_BASE;
      end else if (addr_i < VRAM_CTRL_BASE) begin
         region_o = REG_DECODER;
         base     = DECODER_BASE;
      end else if (addr_i < SPRITE_BASE) begin
         region_o = REG_VRAM_CTRL;
         base     = VRAM_CTRL_BASE;
      end else if (addr_i < TONE_BASE) begin
         region_o = REG_SPRITE;
         base     = SPRITE_BASE;
      end else if (addr_i < MAP_LIMIT) begin
         region_o = REG_TONE;
         base     = TONE_BASE;
      end
   end

   assign mapped_o = (region_o != REG_UNMAPPED);
   assign nibble_o = (region_o == REG_DECODER);
   assign offset_o = mapped_o ? 16'(addr_i - base) : 16'h0000;

endmodule

// File: rtl/ioctl_upload_reader.sv
// HPS upload read-back engine: fetches loader-map bytes from dpram port b and returns them on IOCTL_DIN.
// Optional running byte checksum on CHECKSUM is built only when UPLOAD_CHECKSUM_EN is defined.
module ioctl_upload_reader
   import rom_map_pkg::*;
#(
   parameter int         RD_LAT    = 1,
   parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        IOCTL_UPLOAD,
   input  logic        IOCTL_RD,
   input  logic [24:0] IOCTL_ADDR,
   output logic [7:0]  IOCTL_DIN,
   output logic        IOCTL_WAIT,
   output logic        MEM_RD,
   output logic [2:0]  MEM_SEL,
   output logic [15:0] MEM_ADDR,
   input  logic [7:0]  MEM_DATA,
   output logic        OVERRUN,
   output logic [15:0] CHECKSUM
);

   rd_state_e   state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  din_q, din_d;
   logic        wait_q, wait_d;
   logic        mem_rd_q, mem_rd_d;
   logic [2:0]  sel_q, sel_d;
   logic [15:0] addr_q, addr_d;
   logic        fill_q, fill_d;
   logic        nib_q, nib_d;
   logic        overrun_q, overrun_d;
   logic        upload_q;

   region_e     dec_region;
   logic [15:0] dec_offset;
   logic        dec_mapped;
   logic        dec_nibble;

   logic        accept;
   logic        upload_rise;

   rom_map_decode u_decode (
      .addr_i   (IOCTL_ADDR),
      .region_o (dec_region),
      .offset_o (dec_offset),
      .mapped_o (dec_mapped),
      .nibble_o (dec_nibble)
   );

   assign accept      = (state_q == ST_IDLE) && IOCTL_UPLOAD && IOCTL_RD;
   assign upload_rise = IOCTL_UPLOAD && !upload_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Dropping the upload window always wins over a pending capture.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = dec_mapped ? ST_FETCH : ST_CAPTURE;
         end
         ST_FETCH: begin
            if (!IOCTL_UPLOAD)      state_d = ST_IDLE;
            else if (cnt_q == 2'd1) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      din_d     = din_q;
      wait_d    = wait_q;
      mem_rd_d  = 1'b0;
      sel_d     = sel_q;
      addr_d    = addr_q;
      fill_d    = fill_q;
      nib_d     = nib_q;
      overrun_d = overrun_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               sel_d    = dec_region;
               addr_d   = dec_offset;
               fill_d   = !dec_mapped;
               nib_d    = dec_nibble;
               mem_rd_d = dec_mapped;
               wait_d   = 1'b1;
               cnt_d    = 2'(RD_LAT);
            end
         end
         ST_FETCH: begin
            cnt_d = cnt_q - 2'd1;
            if (!IOCTL_UPLOAD) wait_d = 1'b0;
         end
         ST_CAPTURE: begin
            wait_d = 1'b0;
            if (IOCTL_UPLOAD) begin
               if (fill_q)     din_d = FILL_BYTE;
               else if (nib_q) din_d = {4'h0, MEM_DATA[3:0]};
               else            din_d = MEM_DATA;
            end
         end
         default: wait_d = 1'b0;
      endcase
      if (upload_rise)
         overrun_d = 1'b0;
      else if ((state_q != ST_IDLE) && IOCTL_UPLOAD && IOCTL_RD)
         overrun_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q     <= '0;
         din_q     <= '0;
         wait_q    <= 1'b0;
         mem_rd_q  <= 1'b0;
         sel_q     <= '0;
         addr_q    <= '0;
         fill_q    <= 1'b0;
         nib_q     <= 1'b0;
         overrun_q <= 1'b0;
         upload_q  <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         din_q     <= din_d;
         wait_q    <= wait_d;
         mem_rd_q  <= mem_rd_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         fill_q    <= fill_d;
         nib_q     <= nib_d;
         overrun_q <= overrun_d;
         upload_q  <= IOCTL_UPLOAD;
      end
   end

`ifdef UPLOAD_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;
   logic        commit;

   assign commit = (state_q == ST_CAPTURE) && IOCTL_UPLOAD;

   always_comb begin
      csum_d = csum_q;
      if (upload_rise)  csum_d = '0;
      else if (commit)  csum_d = csum_q + {8'h00, din_d};
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) csum_q <= '0;
      else          csum_q <= csum_d;
   end

   assign CHECKSUM = csum_q;
`else
   assign CHECKSUM = 16'h0000;
`endif

   assign IOCTL_DIN  = din_q;
   assign IOCTL_WAIT = wait_q;
   assign MEM_RD     = mem_rd_q;
   assign MEM_SEL    = sel_q;
   assign MEM_ADDR   = addr_q;
   assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Scoreboard bench for ioctl_upload_reader: two instances (RD_LAT=1 and RD_LAT=3) share stimulus;
// expected bytes and latencies are queued at issue and checked when IOCTL_WAIT falls.
module tb_ioctl_upload_reader;

   logic        clk = 1'b0;
   logic        RESET_N;
   logic        IOCTL_UPLOAD;
   logic        IOCTL_RD;
   logic [24:0] IOCTL_ADDR;
   logic [7:0]  MEM_DATA;

   logic [7:0]  din_a, din_b;
   logic        wt_a, wt_b, mrd_a, mrd_b, ovr_a, ovr_b;
   logic [2:0]  sel_a, sel_b;
   logic [15:0] madr_a, madr_b, cs_a, cs_b;

   typedef struct {
      logic [7:0] din;
      int         lat;
      int         issue;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic wprev_a = 1'b0;
   logic wprev_b = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ioctl_upload_reader #(.RD_LAT(1), .FILL_BYTE(8'hFF)) ua (
      .CLK(clk), .RESET_N(RESET_N), .IOCTL_UPLOAD(IOCTL_UPLOAD), .IOCTL_RD(IOCTL_RD),
      .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DIN(din_a), .IOCTL_WAIT(wt_a), .MEM_RD(mrd_a),
      .MEM_SEL(sel_a), .MEM_ADDR(madr_a), .MEM_DATA(MEM_DATA), .OVERRUN(ovr_a), .CHECKSUM(cs_a)
   );

   ioctl_upload_reader #(.RD_LAT(3), .FILL_BYTE(8'hFF)) ub (
      .CLK(clk), .RESET_N(RESET_N), .IOCTL_UPLOAD(IOCTL_UPLOAD), .IOCTL_RD(IOCTL_RD),
      .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DIN(din_b), .IOCTL_WAIT(wt_b), .MEM_RD(mrd_b),
      .MEM_SEL(sel_b), .MEM_ADDR(madr_b), .MEM_DATA(MEM_DATA), .OVERRUN(ovr_b), .CHECKSUM(cs_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk2(input string nm, input logic [31:0] act_a, input logic [31:0] act_b,
                       input logic [31:0] exp);
      chk({nm, "_a"}, act_a, exp);
      chk({nm, "_b"}, act_b, exp);
   endtask

   function automatic logic [15:0] cs_exp(input logic [15:0] v);
`ifdef UPLOAD_CHECKSUM_EN
      return v;
`else
      return 16'h0000 & v;
`endif
   endfunction

   // Monitors: each falling IOCTL_WAIT is one response to match against the queue head.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (RESET_N && wprev_a && !wt_a) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_a unexpected din %0h want none", din_a);
         end else begin
            e = qa.pop_front();
            chk("din_a", {24'h0, din_a}, {24'h0, e.din});
            chk("lat_a", 32'(cyc - e.issue), 32'(e.lat));
         end
      end
      wprev_a = wt_a;
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (RESET_N && wprev_b && !wt_b) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_b unexpected din %0h want none", din_b);
         end else begin
            e = qb.pop_front();
            chk("din_b", {24'h0, din_b}, {24'h0, e.din});
            chk("lat_b", 32'(cyc - e.issue), 32'(e.lat));
         end
      end
      wprev_b = wt_b;
   end

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (!wt_a && !wt_b && qa.size() == 0 && qb.size() == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL idle_timeout got pending %0d/%0d want 0/0", qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input int lat_a, input int lat_b);
      exp_t e;
      e.din   = d;
      e.issue = cyc + 1;
      e.lat   = lat_a;
      qa.push_back(e);
      e.lat   = lat_b;
      qb.push_back(e);
   endtask

   task automatic do_read(input logic [24:0] a, input logic mapped, input logic [7:0] d,
                          input logic [7:0] exp_din, input logic [2:0] s, input logic [15:0] off);
      @(negedge clk);
      MEM_DATA   = d;
      IOCTL_ADDR = a;
      IOCTL_RD   = 1'b1;
      push_exp(exp_din, mapped ? 2 : 1, mapped ? 4 : 1);
      @(negedge clk);
      IOCTL_RD = 1'b0;
      chk2("wait_rise", wt_a, wt_b, 1);
      chk2("mem_rd", mrd_a, mrd_b, {31'h0, mapped});
      if (mapped) begin
         chk2("mem_sel", sel_a, sel_b, {29'h0, s});
         chk2("mem_addr", madr_a, madr_b, {16'h0, off});
      end
      @(negedge clk);
      chk2("mem_rd_pulse", mrd_a, mrd_b, 0);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0; IOCTL_UPLOAD = 1'b0; IOCTL_RD = 1'b0; IOCTL_ADDR = '0; MEM_DATA = '0;
      repeat (2) @(negedge clk);
      chk2("rst_din", din_a, din_b, 0);
      chk2("rst_wait", wt_a, wt_b, 0);
      chk2("rst_ovr", ovr_a, ovr_b, 0);
      chk2("rst_addr", madr_a, madr_b, 0);
      RESET_N = 1'b1;

      // Read strobe outside the upload window is ignored.
      @(negedge clk); IOCTL_ADDR = 25'h00010; IOCTL_RD = 1'b1;
      @(negedge clk); IOCTL_RD = 1'b0;
      chk2("noupl_wait", wt_a, wt_b, 0);
      chk2("noupl_mrd", mrd_a, mrd_b, 0);

      @(negedge clk); IOCTL_UPLOAD = 1'b1;
      @(negedge clk);

      do_read(25'h00010, 1'b1, 8'hA5, 8'hA5, 3'd0, 16'h0010);
      do_read(25'h14805, 1'b1, 8'h7C, 8'h0C, 3'd3, 16'h0005);
      do_read(25'h14960, 1'b0, 8'h12, 8'hFF, 3'd0, 16'h0000);
      do_read(25'h1FFFF, 1'b0, 8'h34, 8'hFF, 3'd0, 16'h0000);

      // Second strobe one cycle after the first: dropped, OVERRUN sticks.
      @(negedge clk);
      MEM_DATA = 8'h5A; IOCTL_ADDR = 25'h10003; IOCTL_RD = 1'b1;
      push_exp(8'h5A, 2, 4);
      @(negedge clk);
      IOCTL_ADDR = 25'h00020;
      chk2("ovr_sel", sel_a, sel_b, 1);
      chk2("ovr_addr", madr_a, madr_b, 16'h0003);
      @(negedge clk);
      IOCTL_RD = 1'b0;
      chk2("ovr_addr_hold", madr_a, madr_b, 16'h0003);
      wait_idle();
      chk2("overrun", ovr_a, ovr_b, 1);
      chk2("ovr_addr_final", madr_a, madr_b, 16'h0003);

      // Upload window closes during FETCH: abort, data held, checksum untouched.
      @(negedge clk);
      MEM_DATA = 8'h11; IOCTL_ADDR = 25'h00040; IOCTL_RD = 1'b1;
      push_exp(8'h5A, 1, 1);
      @(negedge clk);
      IOCTL_RD = 1'b0; IOCTL_UPLOAD = 1'b0;
      wait_idle();
      chk2("abort_ovr_kept", ovr_a, ovr_b, 1);
      chk2("cs_total", cs_a, cs_b, {16'h0, cs_exp(16'h0309)});

      @(negedge clk); IOCTL_UPLOAD = 1'b1;
      @(negedge clk);
      chk2("ovr_clear", ovr_a, ovr_b, 0);
      chk2("cs_clear", cs_a, cs_b, 0);

      do_read(25'h14960, 1'b0, 8'h00, 8'hFF, 3'd0, 16'h0000);
      do_read(25'h1FFFF, 1'b0, 8'h00, 8'hFF, 3'd0, 16'h0000);
      do_read(25'h00001, 1'b1, 8'h03, 8'h03, 3'd0, 16'h0001);
      chk2("cs_wrap", cs_a, cs_b, {16'h0, cs_exp(16'h0201)});

      // Region boundaries.
      do_read(25'h13FFF, 1'b1, 8'h3C, 8'h3C, 3'd1, 16'h3FFF);
      do_read(25'h14000, 1'b1, 8'h3C, 8'h3C, 3'd2, 16'h0000);
      do_read(25'h148FF, 1'b1, 8'h3C, 8'h0C, 3'd3, 16'h00FF);
      do_read(25'h14900, 1'b1, 8'h3C, 8'h3C, 3'd4, 16'h0000);
      do_read(25'h14920, 1'b1, 8'h3C, 8'h3C, 3'd5, 16'h0000);
      do_read(25'h1495F, 1'b1, 8'h3C, 8'h3C, 3'd6, 16'h001F);

      // Asynchronous reset in the middle of a read.
      @(negedge clk);
      MEM_DATA = 8'h77; IOCTL_ADDR = 25'h00050; IOCTL_RD = 1'b1;
      @(negedge clk);
      IOCTL_RD = 1'b0;
      chk2("pre_rst_wait", wt_a, wt_b, 1);
      #2 RESET_N = 1'b0;
      #1;
      chk2("arst_din", din_a, din_b, 0);
      chk2("arst_wait", wt_a, wt_b, 0);
      chk2("arst_mrd", mrd_a, mrd_b, 0);
      chk2("arst_sel", sel_a, sel_b, 0);
      chk2("arst_addr", madr_a, madr_b, 0);
      chk2("arst_ovr", ovr_a, ovr_b, 0);
      chk2("arst_cs", cs_a, cs_b, 0);
      repeat (2) @(negedge clk);
      RESET_N = 1'b1;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
